// File: rtl/pipelined_adder_seg.sv
// pipelined_adder_seg: unsigned adder whose carry chain is cut into SEG_W-bit slices, one slice per register stage.
// Latency: NUM_SEG = WIDTH/SEG_W cycles from accept to out_valid when unstalled; throughput one op per cycle.
// Backpressure: whole pipe holds while out_valid & ~out_ready; in_ready = ~out_valid | out_ready (no in_valid path).
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake for in1/in2 (WIDTH bits, unsigned)
//   out_valid/out_ready  result handshake for sum (WIDTH bits, modulo 2^WIDTH) and cout
//   ovf                  two's-complement overflow, aligned with sum; only when PIPE_ADD_OVF_EN is defined
module pipelined_adder_seg #(
    parameter int WIDTH = 12,
    parameter int SEG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM_SEG = WIDTH / SEG_W;

    generate
        if ((SEG_W < 1) || (WIDTH < SEG_W) || ((WIDTH % SEG_W) != 0)) begin : g_bad_cfg
            $error("pipelined_adder_seg: WIDTH must be a non-zero multiple of SEG_W");
        end
    endgenerate

    // Stage k registers: valid, carry out of slice k, sum slices 0..k (upper
    // bits zero), and the full operands so later stages can pick their slice.
    logic [NUM_SEG-1:0] vld_q;
    logic [NUM_SEG-1:0] cy_q;
    logic [WIDTH-1:0]   acc_q [NUM_SEG];
    logic [WIDTH-1:0]   opa_q [NUM_SEG];
    logic [WIDTH-1:0]   opb_q [NUM_SEG];

    // Stage k inputs (stage 0 is fed by the ports) and next-state values.
    logic [NUM_SEG-1:0] vld_in;
    logic [NUM_SEG-1:0] cy_in;
    logic [NUM_SEG-1:0] cy_nxt;
    logic [WIDTH-1:0]   acc_in  [NUM_SEG];
    logic [WIDTH-1:0]   opa_in  [NUM_SEG];
    logic [WIDTH-1:0]   opb_in  [NUM_SEG];
    logic [WIDTH-1:0]   acc_nxt [NUM_SEG];
    logic [SEG_W:0]     slice_sum;

    logic adv;

    // The output register is the last stage, so a held result freezes every
    // stage behind it; there is no partial advance into empty slots.
    assign adv      = ~vld_q[NUM_SEG-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        vld_in[0] = in_valid;
        cy_in[0]  = 1'b0;
        acc_in[0] = '0;
        opa_in[0] = in1;
        opb_in[0] = in2;
        for (int k = 1; k < NUM_SEG; k++) begin
            vld_in[k] = vld_q[k-1];
            cy_in[k]  = cy_q[k-1];
            acc_in[k] = acc_q[k-1];
            opa_in[k] = opa_q[k-1];
            opb_in[k] = opb_q[k-1];
        end

        slice_sum = '0;
        for (int k = 0; k < NUM_SEG; k++) begin
            slice_sum = {1'b0, opa_in[k][k*SEG_W +: SEG_W]}
                      + {1'b0, opb_in[k][k*SEG_W +: SEG_W]}
                      + {{SEG_W{1'b0}}, cy_in[k]};
            acc_nxt[k]                   = acc_in[k];
            acc_nxt[k][k*SEG_W +: SEG_W] = slice_sum[SEG_W-1:0];
            cy_nxt[k]                    = slice_sum[SEG_W];
        end
    end

    // Bubbles load zero data so an idle output reads back as all zeros and
    // operand values presented without in_valid never reach the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < NUM_SEG; k++) begin
                acc_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < NUM_SEG; k++) begin
                vld_q[k] <= vld_in[k];
                if (vld_in[k]) begin
                    cy_q[k]  <= cy_nxt[k];
                    acc_q[k] <= acc_nxt[k];
                    opa_q[k] <= opa_in[k];
                    opb_q[k] <= opb_in[k];
                end else begin
                    cy_q[k]  <= 1'b0;
                    acc_q[k] <= '0;
                    opa_q[k] <= '0;
                    opb_q[k] <= '0;
                end
            end
        end
    end

    assign out_valid = vld_q[NUM_SEG-1];
    assign sum       = acc_q[NUM_SEG-1];
    assign cout      = cy_q[NUM_SEG-1];

`ifdef PIPE_ADD_OVF_EN
    // The operand MSBs travel with the operands to the last stage, which also
    // produces the sum MSB, so overflow is formed there and registered
    // alongside the sum.
    logic ovf_q;
    logic ovf_nxt;

    assign ovf_nxt = (opa_in[NUM_SEG-1][WIDTH-1] == opb_in[NUM_SEG-1][WIDTH-1])
                   && (acc_nxt[NUM_SEG-1][WIDTH-1] != opa_in[NUM_SEG-1][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= vld_in[NUM_SEG-1] & ovf_nxt;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_seg.sv
`timescale 1ns/1ps
// tb_pipelined_adder_seg: random + directed stimulus against a queue-based reference model.
// Latency: checks NUM_SEG-cycle result latency and back-to-back streaming.
// Backpressure: checks output hold, in_ready drop and lossless in-order drain.
module tb_pipelined_adder_seg;

    localparam int WIDTH   = 12;
    localparam int SEG_W   = 6;
    localparam int NUM_SEG = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_ADD_OVF_EN
    logic             ovf;
`endif

    pipelined_adder_seg #(
        .WIDTH (WIDTH),
        .SEG_W (SEG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [13:0] exp_q[$];      // {ovf, cout, sum} of accepted ops, in order
    int          emit_cyc[$];
    logic        stalled_prev = 1'b0;
    logic [14:0] held;
    logic        last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: plain 13-bit addition; ovf from the two's-complement rule.
    function automatic logic [13:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        logic           v;
        s = {1'b0, a} + {1'b0, b};
        v = 1'b0;
`ifdef PIPE_ADD_OVF_EN
        v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`endif
        return {v, s};
    endfunction

    function automatic logic [14:0] obs();
`ifdef PIPE_ADD_OVF_EN
        return {out_valid, ovf, cout, sum};
`else
        return {out_valid, 1'b0, cout, sum};
`endif
    endfunction

    // Called just after a falling edge with inputs already driven: samples the
    // handshakes that the next rising edge will act on, then advances one cycle.
    task automatic tick();
        logic [14:0] o;
        logic [13:0] e;
        #1;
        last_acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            stalled_prev = 1'b0;
        end else begin
            o = obs();
            if (stalled_prev) check("hold_stable", 32'(o), 32'(held));
            if (out_valid && out_ready) begin
                emit_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_dat", 32'(o[13:0]), 32'(e));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in1, in2));
                last_acc = 1'b1;
            end
            stalled_prev = out_valid && !out_ready;
            held         = o;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int guard;
        guard    = 0;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        do begin
            tick();
            guard++;
        end while (!last_acc && guard < 100);
        if (!last_acc) check("send_timeout", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
            tick();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [WIDTH-1:0] sa [4] = '{12'h001, 12'h0FF, 12'hABC, 12'hFFF};
    logic [WIDTH-1:0] sb [4] = '{12'h002, 12'h001, 12'h111, 12'hFFF};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef PIPE_ADD_OVF_EN
        check("rst_ovf",       32'(ovf),       32'd0);
`endif

        // Carry across the slice boundary, with latency
        out_ready = 1'b1;
        send(12'h03F, 12'h001);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("carry_sum", 32'(sum),       32'h040);
        check("carry_cout", 32'(cout),     32'd0);
        drain();

        // Wrap-around and overflow corners
        send(12'hFFF, 12'h001);
        send(12'h800, 12'h800);
        send(12'h7FF, 12'h001);
        drain();

        // Streaming: four back-to-back ops emerge on consecutive cycles
        emit_cyc.delete();
        for (int i = 0; i < 4; i++) send(sa[i], sb[i]);
        drain();
        check("stream_count", 32'(emit_cyc.size()), 32'd4);
        if (emit_cyc.size() == 4)
            check("stream_gap", 32'(emit_cyc[3] - emit_cyc[0]), 32'd3);

        // Backpressure: fill the pipe, offer a third op, hold for 5 cycles
        out_ready = 1'b0;
        send(12'h111, 12'h222);
        send(12'h333, 12'hCCD);
        in1      = 12'h5A5;
        in2      = 12'hA5A;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;   // accept and emit in the same cycle
        tick();
        check("bp_accept_on_release", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        drain();

        // Reset one cycle after an accept discards the op
        send(12'h123, 12'h456);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_mid_valid", 32'(out_valid), 32'd0);
            tick();
        end

        // Randomised traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 7))
                0:       begin in1 = 12'hFFF; in2 = 12'($urandom_range(0, 4095)); end
                1:       begin in1 = 12'h800; in2 = 12'h800; end
                2:       begin in1 = 12'h7FF; in2 = 12'($urandom_range(0, 15)); end
                default: begin in1 = 12'($urandom_range(0, 4095)); in2 = 12'($urandom_range(0, 4095)); end
            endcase
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
